// File: rtl/stack_calculator_if.sv
// Op handshake and result strobe between a host and the stack calculator.
interface stack_calculator_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;
    logic             ready;

    modport master (output in_valid, opcode, operand, input in_ready, result, ready);
    modport slave  (input in_valid, opcode, operand, output in_ready, result, ready);
endinterface

// File: rtl/stack_calculator.sv
// Parenthesised RPN-style calculator: operand stack, frame markers, multicycle MUL.
// state    | meaning
// RUN      | accepting ops
// MUL_BUSY | multiply in flight, commits WIDTH cycles after acceptance
// ERROR    | sticky fault, only CLEAR has effect
module stack_calculator #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    stack_calculator_if.slave          bus,
    output logic                       overflow,
    output logic                       error,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] depth
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(FRAMES + 1);
    localparam int FA = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000, OP_MUL = 3'b001, OP_OPEN = 3'b010, OP_CLOSE = 3'b011,
                           OP_PUSH = 3'b100, OP_EQUAL = 3'b101, OP_SUB = 3'b110, OP_CLEAR = 3'b111;
    localparam logic [1:0] E_NONE = 2'b00, E_UNDER = 2'b01, E_CAP = 2'b10, E_STRUCT = 2'b11;

    typedef enum logic [1:0] {RUN, MUL_BUSY, ERROR} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] stack [DEPTH];
    logic [DW-1:0]    base  [FRAMES];
    logic [DW-1:0]    sp;
    logic [FW-1:0]    nframes;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] mul_a, mul_b, res;
    logic             rdy, ovf, err;
    logic [1:0]       code;

    logic             accept, clear;
    logic [1:0]       fault;
    logic [DW-1:0]    cur_base, above;
    logic [AW-1:0]    top_idx, sec_idx;
    logic [WIDTH-1:0] a, b, sum, diff;
    logic             add_ovf, sub_ovf, mul_ovf;
    logic signed [2*WIDTH-1:0] prod_full;

    assign bus.in_ready = (state != MUL_BUSY);
    assign bus.result   = res;
    assign bus.ready    = rdy;
    assign overflow     = ovf;
    assign error        = err;
    assign err_code     = code;
    assign depth        = sp;

    assign accept   = bus.in_valid && bus.in_ready;
    assign clear    = accept && (bus.opcode == OP_CLEAR);
    assign cur_base = (nframes == '0) ? '0 : base[FA'(nframes - 1'b1)];
    assign above    = sp - cur_base;
    assign top_idx  = AW'(sp - 1'b1);
    assign sec_idx  = AW'(sp - DW'(2));
    assign a        = stack[sec_idx];
    assign b        = stack[top_idx];
    assign sum      = a + b;
    assign diff     = a - b;
    assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign prod_full = $signed(mul_a) * $signed(mul_b);
    // Product fits only if the top WIDTH+1 bits are a pure sign extension.
    assign mul_ovf  = !((&prod_full[2*WIDTH-1:WIDTH-1]) || !(|prod_full[2*WIDTH-1:WIDTH-1]));

    always_comb begin
        fault = E_NONE;
        case (bus.opcode)
            OP_ADD, OP_SUB, OP_MUL: if (above < DW'(2)) fault = E_UNDER;
            OP_OPEN:  if (nframes == FW'(FRAMES)) fault = E_CAP;
            OP_CLOSE: if (nframes == '0 || above != DW'(1)) fault = E_STRUCT;
            OP_PUSH:  if (sp == DW'(DEPTH)) fault = E_CAP;
            OP_EQUAL: if (nframes != '0 || sp != DW'(1)) fault = E_STRUCT;
            default:  fault = E_NONE;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: if (accept && !clear) begin
                if (fault != E_NONE)          state_next = ERROR;
                else if (bus.opcode == OP_MUL) state_next = MUL_BUSY;
            end
            MUL_BUSY: if (timer == '0) state_next = RUN;
            ERROR:    if (clear) state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            sp      <= '0;
            nframes <= '0;
            timer   <= '0;
            res     <= '0;
            rdy     <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            code    <= E_NONE;
        end else begin
            state <= state_next;
            rdy   <= 1'b0;
            if (rdy) ovf <= 1'b0;
            if (clear) begin
                sp      <= '0;
                nframes <= '0;
                ovf     <= 1'b0;
                err     <= 1'b0;
                code    <= E_NONE;
            end else if (state == RUN && accept) begin
                if (fault != E_NONE) begin
                    err  <= 1'b1;
                    code <= fault;
                end else begin
                    case (bus.opcode)
                        OP_PUSH: begin
                            stack[AW'(sp)] <= bus.operand;
                            sp <= sp + 1'b1;
                        end
                        OP_ADD: begin
                            stack[sec_idx] <= sum;
                            sp <= sp - 1'b1;
                            if (add_ovf) ovf <= 1'b1;
                        end
                        OP_SUB: begin
                            stack[sec_idx] <= diff;
                            sp <= sp - 1'b1;
                            if (sub_ovf) ovf <= 1'b1;
                        end
                        OP_MUL: begin
                            mul_a <= a;
                            mul_b <= b;
                            timer <= TW'(WIDTH - 1);
                        end
                        OP_OPEN: begin
                            base[FA'(nframes)] <= sp;
                            nframes <= nframes + 1'b1;
                        end
                        OP_CLOSE: nframes <= nframes - 1'b1;
                        OP_EQUAL: begin
                            res <= b;
                            rdy <= 1'b1;
                            sp  <= '0;
                        end
                        default: ;
                    endcase
                end
            end else if (state == MUL_BUSY) begin
                if (timer == '0) begin
                    stack[sec_idx] <= prod_full[WIDTH-1:0];
                    sp <= sp - 1'b1;
                    if (mul_ovf) ovf <= 1'b1;
                end else begin
                    timer <= timer - 1'b1;
                end
            end
        end
    end
endmodule
